// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width, scheduler state encoding and a constant max helper.
package uart_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: valid/ready byte stream from the producer into the scheduler.
interface uart_tx_sched_if;
  import uart_pkg::*;
  logic              valid;
  logic [BYTE_W-1:0] data;
  logic              ready;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/uart_tx_sched_sync_fifo.sv
// sync_fifo: synchronous FIFO with wrap-bit pointers, combinational head and sync flush.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = wr_ptr == rd_ptr;
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: buffers producer bytes and launches them one at a time into the UART transmitter.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int FIFO_AW  = 4,
  parameter int BUSY_TMO = 16,
  parameter int IDLE_GAP = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_sched_if.slave      stream,
  input  logic                flush,
  input  logic                uart_tx_busy,
  output logic                uart_tx_en,
  output logic [BYTE_W-1:0]   uart_tx_data,
  output logic [FIFO_AW:0]    fifo_count,
  output logic                tmo_err
);
  localparam int CW = $clog2(max2(BUSY_TMO, IDLE_GAP) + 1);
  state_t            state, state_d;
  logic [CW-1:0]     cnt;
  logic              pop, cnt_clr, cnt_inc, tmo;
  logic              full, empty;
  logic [BYTE_W-1:0] head;
  assign stream.ready = ~full;
  sync_fifo #(.DW(BYTE_W), .AW(FIFO_AW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(stream.valid & ~full),
    .pop(pop),
    .flush(flush),
    .din(stream.data),
    .dout(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    tmo     = 1'b0;
    case (state)
      S_IDLE: if (!empty && !uart_tx_busy && !flush) begin
        pop     = 1'b1;
        state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        cnt_clr = 1'b1;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (uart_tx_busy) state_d = S_WAIT_DONE;
        else if (cnt == CW'(BUSY_TMO - 1)) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end else cnt_inc = 1'b1;
      S_WAIT_DONE: if (!uart_tx_busy) begin
        cnt_clr = 1'b1;
        state_d = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: if (cnt == CW'(IDLE_GAP - 1)) state_d = S_IDLE;
        else cnt_inc = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
  // en is registered off LAUNCH so it sits on the cycle after the head byte is latched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      tmo_err      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_clr ? '0 : cnt + CW'(cnt_inc);
      uart_tx_en <= state == S_LAUNCH;
      tmo_err    <= tmo;
      if (pop) uart_tx_data <= head;
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized scenarios against a behavioural transmitter and an in-order byte scoreboard.
module tb_uart_tx_sched;
  import uart_pkg::*;
  localparam int AW = 4, DEPTH = 16, TMO = 16, BIT_CYC = 4;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic busy, en, tmo_err, line;
  logic [7:0] tx_data;
  logic [AW:0] count;
  int vectors = 0, miscompares = 0;
  uart_tx_sched_if sif();
  uart_tx_sched #(.FIFO_AW(AW), .BUSY_TMO(TMO), .IDLE_GAP(0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stream(sif),
    .flush(flush),
    .uart_tx_busy(busy),
    .uart_tx_en(en),
    .uart_tx_data(tx_data),
    .fifo_count(count),
    .tmo_err(tmo_err)
  );
  always #5 clk = ~clk;
  // transmitter model: busy one cycle after en, 10 bit times long, LSB-first frame on line
  int tx_left;
  logic [9:0] frame;
  bit dead = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin busy <= 1'b0; tx_left <= 0; frame <= '1; end
    else if (en && !dead) begin busy <= 1'b1; tx_left <= 10 * BIT_CYC; frame <= {1'b1, tx_data, 1'b0}; end
    else if (tx_left > 1) tx_left <= tx_left - 1;
    else begin busy <= 1'b0; tx_left <= 0; end
  assign line = busy ? frame[(10 * BIT_CYC - tx_left) / BIT_CYC] : 1'b1;
  int cyc = 0, en_cnt = 0, tmo_cnt = 0, en_cyc = 0, tmo_cyc = 0, viol = 0, max_count = 0;
  logic en_prev = 1'b0;
  logic [7:0] sent[$], exp_q[$];
  always @(negedge clk) begin
    cyc++;
    if (en) begin en_cnt++; en_cyc = cyc; sent.push_back(tx_data); end
    if (en && (busy || en_prev)) viol++;
    if (sif.ready !== (count != DEPTH)) viol++;
    if (int'(count) > max_count) max_count = int'(count);
    if (tmo_err) begin tmo_cnt++; tmo_cyc = cyc; end
    en_prev = en;
  end
  task automatic push_byte(input logic [7:0] b);
    int w = 0;
    sif.valid = 1'b1;
    sif.data  = b;
    while (!sif.ready && w < 2000) begin @(posedge clk); #1; w++; end
    vectors++;
    if (!sif.ready) begin miscompares++; $display("FAIL push_stall ready=%b required 1", sif.ready); end
    else exp_q.push_back(b);
    @(posedge clk); #1;
    sif.valid = 1'b0;
  endtask
  task automatic wait_quiet();
    int q = 0, w = 0;
    while (q < 8 && w < 5000) begin
      @(posedge clk); #1; w++;
      q = (count == 0 && !busy && !en) ? q + 1 : 0;
    end
    vectors++;
    if (q < 8) begin miscompares++; $display("FAIL drain_timeout count=%0d busy=%b required idle", count, busy); end
  endtask
  task automatic check_sent(input string name);
    vectors++;
    if (sent.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_len sent %0d bytes required %0d", name, sent.size(), exp_q.size());
    end
    for (int i = 0; i < sent.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (sent[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_byte%0d got %h required %h", name, i, sent[i], exp_q[i]);
      end
    end
    sent.delete();
    exp_q.delete();
  endtask
  task automatic test_reset();
    sif.valid = 1'b0; sif.data = '0; rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    vectors += 5;
    if (sif.ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b required 1", sif.ready); end
    if (en !== 1'b0) begin miscompares++; $display("FAIL rst_en got %b required 0", en); end
    if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_data got %h required 00", tx_data); end
    if (count !== '0) begin miscompares++; $display("FAIL rst_count got %0d required 0", count); end
    if (tmo_err !== 1'b0) begin miscompares++; $display("FAIL rst_tmo got %b required 0", tmo_err); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    vectors++;
    if (en_cnt != 0) begin miscompares++; $display("FAIL rst_idle_en got %0d pulses required 0", en_cnt); end
  endtask
  task automatic test_single();
    logic [9:0] got, want;
    int w = 0;
    want = 10'b1101001010;
    en_cnt = 0;
    push_byte(8'hA5);
    @(posedge clk); #1;
    vectors++;
    if (en !== 1'b0) begin miscompares++; $display("FAIL lat_early en=%b required 0", en); end
    @(posedge clk); #1;
    vectors += 2;
    if (en !== 1'b1) begin miscompares++; $display("FAIL lat_en en=%b required 1", en); end
    if (tx_data !== 8'hA5) begin miscompares++; $display("FAIL single_data got %h required a5", tx_data); end
    while (!busy && w < 50) begin @(posedge clk); #1; w++; end
    for (int i = 0; i < 10; i++) begin
      repeat (i == 0 ? 2 : BIT_CYC) @(posedge clk);
      #1 got[i] = line;
    end
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL single_line got %b required %b", got, want); end
    wait_quiet();
    vectors += 2;
    if (count !== '0) begin miscompares++; $display("FAIL single_count got %0d required 0", count); end
    if (en_cnt != 1) begin miscompares++; $display("FAIL single_pulses got %0d required 1", en_cnt); end
    check_sent("single");
  endtask
  task automatic test_burst(input string name, input int n, input bit ramp, input int want_max);
    en_cnt = 0; max_count = 0; viol = 0;
    for (int i = 0; i < n; i++) push_byte(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
    wait_quiet();
    vectors += 3;
    if (en_cnt != n) begin miscompares++; $display("FAIL %s_pulses got %0d required %0d", name, en_cnt, n); end
    if (viol != 0) begin miscompares++; $display("FAIL %s_protocol got %0d violations required 0", name, viol); end
    if (max_count != want_max) begin miscompares++; $display("FAIL %s_max_count got %0d required %0d", name, max_count, want_max); end
    check_sent(name);
  endtask
  task automatic test_tmo();
    int w = 0;
    en_cnt = 0; tmo_cnt = 0; dead = 1;
    push_byte(8'h3C);
    while (tmo_cnt == 0 && w < 200) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    vectors += 3;
    if (tmo_cnt != 1) begin miscompares++; $display("FAIL tmo_pulse got %0d pulses required 1", tmo_cnt); end
    if (tmo_cyc - en_cyc != TMO) begin miscompares++; $display("FAIL tmo_delay got %0d cycles required %0d", tmo_cyc - en_cyc, TMO); end
    if (tmo_err !== 1'b0) begin miscompares++; $display("FAIL tmo_width tmo_err=%b required 0", tmo_err); end
    dead = 0;
    push_byte(8'($urandom_range(0, 255)));
    wait_quiet();
    vectors += 2;
    if (en_cnt != 2) begin miscompares++; $display("FAIL tmo_next got %0d pulses required 2", en_cnt); end
    if (tmo_cnt != 1) begin miscompares++; $display("FAIL tmo_extra got %0d pulses required 1", tmo_cnt); end
    check_sent("tmo");
  endtask
  task automatic test_flush_reset();
    int w = 0;
    en_cnt = 0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)));
    vectors++;
    if (count !== 5) begin miscompares++; $display("FAIL flush_pre_count got %0d required 5", count); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors += 2;
    if (count !== '0) begin miscompares++; $display("FAIL flush_count got %0d required 0", count); end
    if (!busy) begin miscompares++; $display("FAIL flush_inflight busy=%b required 1", busy); end
    wait_quiet();
    vectors++;
    if (en_cnt != 1) begin miscompares++; $display("FAIL flush_pulses got %0d required 1", en_cnt); end
    exp_q = exp_q[0:0];
    check_sent("flush");
    push_byte(8'($urandom_range(0, 255)));
    push_byte(8'($urandom_range(0, 255)));
    while (!busy && w < 50) begin @(posedge clk); #1; w++; end
    #2 rst_n = 1'b0;
    #1;
    vectors += 5;
    if (sif.ready !== 1'b1) begin miscompares++; $display("FAIL arst_ready got %b required 1", sif.ready); end
    if (en !== 1'b0) begin miscompares++; $display("FAIL arst_en got %b required 0", en); end
    if (tx_data !== 8'h00) begin miscompares++; $display("FAIL arst_data got %h required 00", tx_data); end
    if (count !== '0) begin miscompares++; $display("FAIL arst_count got %0d required 0", count); end
    if (tmo_err !== 1'b0) begin miscompares++; $display("FAIL arst_tmo got %b required 0", tmo_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    en_cnt = 0;
    repeat (20) @(posedge clk); #1;
    vectors++;
    if (en_cnt != 0) begin miscompares++; $display("FAIL arst_after got %0d pulses required 0", en_cnt); end
    sent.delete();
    exp_q.delete();
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout at %0t required finish", $time);
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_burst("burst16", 16, 1'b1, 15);
    test_burst("burst17", 17, 1'b0, 16);
    test_burst("full", 24, 1'b0, 16);
    test_tmo();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
